multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Control FSM that sequences the shared CPU datapath (imem, reg_file, ALU, dmem) one instruction at a time.
- Executes the supported subset: add/sub/and/or, addi, ld, sd, beq.
- Drives the datapath control strobes, detects the all-zero halt word and illegal encodings, and handles a dmem ready handshake.
- Keeps cycle and retired-instruction counters for execution-time reporting.

Parameters:
- CNT_W, 32, width of cycle_count and instr_count.
- WAIT_LIMIT, 16, maximum consecutive mem_ready-low cycles in MEM before a trap.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  current instruction from the IR; stable from DECODE to the end of the instruction.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  dmem handshake; access completes in the cycle this is high.
- ir_write  out  1  latch imem output into the IR.
- pc_write  out  1  update PC this cycle.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write enable.
- mem_read  out  1  dmem read request.
- mem_write  out  1  dmem write request.
- mem_to_reg  out  1  writeback mux select, 1 = dmem data.
- alu_src  out  1  ALU B mux select, 1 = immediate.
- alu_op  out  2  00 add, 01 sub (beq), 10 decode funct3/funct7.
- branch  out  1  high during beq EXECUTE.
- state  out  3  current FSM state, for debug.
- halted  out  1  sticky halt indication.
- trap  out  1  sticky illegal/timeout indication.
- cycle_count  out  CNT_W  active cycles since reset.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset: while reset is high, next state is FETCH and all counters and the wait counter clear. All outputs are 0 in the reset cycle, except state, which shows FETCH once the first clock edge completes. Reset asserted in any state, including MEM mid-access or HALT, aborts immediately with no write strobes in that cycle.
- States (3-bit): FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, TRAP=6.
- Outputs are combinational from state and instr. Every strobe not listed for a state is 0.
- FETCH: ir_write=1, then go to DECODE.
- DECODE: no strobes.
  - If instr==0, go to HALT.
  - Else if the encoding is illegal, go to TRAP.
  - Else go to EXECUTE.
- Legal encodings:
  - opcode 0110011 with funct3 000 (funct7 0000000 or 0100000), 111, or 110 (funct7 0000000);
  - 0010011 with funct3 000;
  - 0000011 with funct3 011;
  - 0100011 with funct3 011;
  - 1100011 with funct3 000.
- EXECUTE:
  - R-type: alu_op=10, alu_src=0.
  - addi, ld, sd: alu_op=00, alu_src=1.
  - beq: alu_op=01, alu_src=0, branch=1, pc_write=1, pc_src=zero; next state FETCH.
  - R-type and addi go to WRITEBACK; ld and sd go to MEM.
- MEM:
  - mem_read (ld) or mem_write (sd) is held high every cycle until mem_ready=1. alu_op=00 and alu_src=1 are also held.
  - On mem_ready=1: sd asserts pc_write and goes to FETCH; ld goes to WRITEBACK.
  - Wait counter: increments on each mem_ready=0 cycle and clears on leaving MEM. When it reaches WAIT_LIMIT, go to TRAP with no further strobes.
- WRITEBACK: reg_write=1 (forced 0 when instr[11:7]==0), mem_to_reg=1 for ld, pc_write=1, pc_src=0; next state FETCH.
- HALT / TRAP: terminal until reset. halted=1 (HALT) or trap=1 (TRAP) from the first cycle in the state. All strobes are 0.
- Latency:
  - beq: 3 cycles.
  - R-type / addi: 4 cycles.
  - sd: 4 + waits.
  - ld: 5 + waits.
- Counters:
  - cycle_count increments every non-reset cycle while not in HALT or TRAP.
  - instr_count increments on every pc_write cycle.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package cpu_ctrl_pkg holds: state encodings, opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), funct3 constants, and alu_op codes.
- One sub-module, instr_legal_check: a purely combinational legality decoder on instr, reused by the bench's disassembler checks.

Test Plan:
- addi x1,x0,5 (0x00500093) after reset: state sequence 0,1,2,4. alu_src=1, alu_op=00. reg_write and pc_write only in cycle 4, pc_src=0. instr_count=1, cycle_count=4.
- beq x1,x0,32 (0x02008063): with zero=1, pc_write=1 and pc_src=1 in EXECUTE, 3 cycles. Repeat with zero=0: pc_src=0, still 3 cycles.
- ld x3,0(x1) (0x0000B183) with mem_ready low 2 cycles: mem_read high 3 consecutive cycles, mem_to_reg=1 in WRITEBACK, total 7 cycles. With mem_ready held low 16 cycles: trap=1, reg_write never asserted.
- add x0,x1,x2 (0x00208033): WRITEBACK with reg_write=0 and pc_write=1. xor x3,x1,x2 (0x0020C1B3): TRAP after DECODE, trap=1, no pc_write, counters frozen.
- instr=0x00000000 after 3 retired instructions: halted=1 from the cycle after DECODE. instr_count stays 3 and cycle_count stops incrementing over 10 further cycles.
- reset pulsed during MEM with mem_write=1: mem_write=0 in the reset cycle, state=FETCH and counters 0 after the edge, and the next addi runs normally.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states,
// major opcodes, funct fields and ALU operation codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_TRAP      = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/instr_legal_check.sv
// Combinational legality decoder for the supported instruction subset.
// Also flags the all-zero halt word.
module instr_legal_check
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output logic        halt_word
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign halt_word = (instr == 32'd0);

    // Accept only encodings the control sequence knows how to execute
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                legal = ((funct3 == F3_ADD_SUB) && ((funct7 == F7_BASE) || (funct7 == F7_SUB)))
                     || (((funct3 == F3_AND) || (funct3 == F3_OR)) && (funct7 == F7_BASE));
            end
            OP_IMM:    legal = (funct3 == F3_ADD_SUB);
            OP_LOAD:   legal = (funct3 == F3_DWORD);
            OP_STORE:  legal = (funct3 == F3_DWORD);
            OP_BRANCH: legal = (funct3 == F3_BEQ);
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences imem/regfile/ALU/dmem strobes one
// instruction at a time, with dmem wait timeout and execution counters.
//
// state     | meaning
// FETCH     | latch imem word into IR
// DECODE    | classify instr: halt word, illegal, or execute
// EXECUTE   | ALU op; beq resolves and updates PC here
// MEM       | ld/sd access, held until mem_ready or timeout
// WRITEBACK | register write and PC+4
// HALT      | terminal, halt word seen
// TRAP      | terminal, illegal encoding or dmem timeout
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic [2:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int              WAIT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;

    logic legal, halt_word;
    logic is_r, is_imm, is_load, is_store, is_branch, rd_zero;

    instr_legal_check u_legal (
        .instr     (instr),
        .legal     (legal),
        .halt_word (halt_word)
    );

    assign is_r      = (instr[6:0] == OP_R);
    assign is_imm    = (instr[6:0] == OP_IMM);
    assign is_load   = (instr[6:0] == OP_LOAD);
    assign is_store  = (instr[6:0] == OP_STORE);
    assign is_branch = (instr[6:0] == OP_BRANCH);
    assign rd_zero   = (instr[11:7] == 5'd0);

    // State, wait counter and execution counters; reset clears all
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cycle_q <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_d;
            icnt_q  <= icnt_d;
        end
    end

    // Next-state sequencing; the wait counter only survives while stalled in MEM
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (halt_word)   state_d = S_HALT;
                else if (!legal) state_d = S_TRAP;
                else             state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_branch)                 state_d = S_FETCH;
                else if (is_load || is_store)  state_d = S_MEM;
                else                           state_d = S_WRITEBACK;
            end
            S_MEM: begin
                if (mem_ready)               state_d = is_load ? S_WRITEBACK : S_FETCH;
                else if (wait_q == WAIT_LAST) state_d = S_TRAP;
                else                          wait_d  = wait_q + WAIT_W'(1);
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Datapath strobes from state and instr; all forced low during reset
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        branch     = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: ir_write = 1'b1;
                S_EXECUTE: begin
                    if (is_r) begin
                        alu_op = ALU_FUNCT;
                    end else if (is_branch) begin
                        alu_op   = ALU_SUB;
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end else if (is_imm || is_load || is_store) begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                    end
                end
                S_MEM: begin
                    alu_op    = ALU_ADD;
                    alu_src   = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    pc_write  = mem_ready && is_store;
                end
                S_WRITEBACK: begin
                    reg_write  = !rd_zero;
                    mem_to_reg = is_load;
                    pc_write   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                S_TRAP:  trap   = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating cycle and retired-instruction counters
    always_comb begin
        cycle_d = cycle_q;
        icnt_d  = icnt_q;
        if ((state_q != S_HALT) && (state_q != S_TRAP) && (cycle_q != '1))
            cycle_d = cycle_q + CNT_W'(1);
        if (pc_write && (icnt_q != '1))
            icnt_d = icnt_q + CNT_W'(1);
    end

    assign state       = state_q;
    assign cycle_count = reset ? '0 : cycle_q;
    assign instr_count = reset ? '0 : icnt_q;

endmodule
